// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes, pause/resume
// and an external tick enable; emits a registered one-cycle terminal-count pulse.
module down_counter_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  input  logic             auto_reload,
  output logic [CNT_W-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (count_q != CNT_ZERO)) state_d = RUN;
        end
        RUN: begin
          // stop outranks tick; start is a no-op here so tick proceeds normally
          if (stop) begin
            state_d = HOLD;
          end else if (tick) begin
            if (count_q == CNT_ONE) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = CNT_ZERO;
                state_d = DONE;
              end
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end
        end
        HOLD: begin
          if (start) state_d = RUN;
        end
        DONE: begin
          if (start && (reload_q != CNT_ZERO)) begin
            count_d = reload_q;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign zero  = (count_q == CNT_ZERO);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_down_counter_timer;

  logic        clk = 1'b0;
  logic        rst, load, start, stop, tick, auto_reload;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        tc, busy, done, zero;

  logic       rst4, load4, start4, stop4, tick4, ar4;
  logic [3:0] lv4, count4;
  logic       tc4, busy4, done4, zero4;

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  // behavioural model: plain flags and counters
  bit          m_running, m_paused, m_finished, m_tc;
  logic [15:0] m_cnt, m_period;

  down_counter_timer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .tick(tick), .auto_reload(auto_reload), .count(count),
    .tc(tc), .busy(busy), .done(done), .zero(zero)
  );

  down_counter_timer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .load(load4), .load_val(lv4), .start(start4),
    .stop(stop4), .tick(tick4), .auto_reload(ar4), .count(count4),
    .tc(tc4), .busy(busy4), .done(done4), .zero(zero4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 0; start = 0; stop = 0; tick = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_running = 0; m_paused = 0; m_finished = 0; m_tc = 0;
      m_cnt = 0; m_period = 0;
    end else if (load) begin
      m_cnt = load_val; m_period = load_val;
      m_running = 0; m_paused = 0; m_finished = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (m_running) begin
        if (stop) begin
          m_running = 0; m_paused = 1;
        end else if (tick) begin
          if (m_cnt == 1) begin
            m_tc = 1;
            if (auto_reload) m_cnt = m_period;
            else begin m_cnt = 0; m_running = 0; m_finished = 1; end
          end else m_cnt = m_cnt - 1;
        end
      end else if (m_paused) begin
        if (start) begin m_paused = 0; m_running = 1; end
      end else if (m_finished) begin
        if (start && m_period != 0) begin
          m_cnt = m_period; m_finished = 0; m_running = 1;
        end
      end else if (start && m_cnt != 0) m_running = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model count", count, m_cnt);
      chk("model tc", tc, m_tc);
      chk("model busy", busy, m_running);
      chk("model done", done, m_finished);
      chk("model zero", zero, m_cnt == 0);
    end
  end

  initial begin
    int exp_seq[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    int n;
    rst = 1; idle_inputs(); auto_reload = 0; load_val = 0;
    rst4 = 1; load4 = 0; start4 = 0; stop4 = 0; tick4 = 0; ar4 = 0; lv4 = 0;

    // reset then idle
    cyc(); cmp_en = 1'b1; cyc();
    chk("rst count", count, 0); chk("rst zero", zero, 1);
    chk("rst busy", busy, 0); chk("rst done", done, 0); chk("rst tc", tc, 0);
    rst = 0; start = 1; cyc(); start = 0;
    chk("start@0 busy", busy, 0); chk("start@0 tc", tc, 0);
    cyc(); chk("start@0 tc2", tc, 0);

    // one-shot of 5
    load_val = 5; load = 1; cyc(); load = 0;
    chk("os load count", count, 5);
    start = 1; cyc(); start = 0;
    chk("os busy", busy, 1); chk("os count", count, 5);
    tick = 1;
    for (int i = 4; i >= 0; i--) begin
      cyc();
      chk("os seq", count, i);
      chk("os tc", tc, i == 0);
    end
    chk("os done", done, 1); chk("os busy end", busy, 0);
    tick = 0; cyc();
    chk("os tc off", tc, 0); chk("os done hold", done, 1);

    // auto-reload of 3
    load_val = 3; auto_reload = 1; load = 1; cyc(); load = 0;
    start = 1; cyc(); start = 0; tick = 1;
    chk("ar first", count, 3);
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("ar seq", count, exp_seq[i]);
      chk("ar tc", tc, exp_seq[i] == 3);
      chk("ar done", done, 0);
    end
    tick = 0; auto_reload = 0;

    // pause/resume with gated ticks
    load_val = 8; load = 1; cyc(); load = 0;
    start = 1; cyc(); start = 0;
    tick = 1; cyc(); cyc();
    chk("pr two ticks", count, 6);
    stop = 1; cyc(); stop = 0;
    chk("pr hold count", count, 6); chk("pr hold busy", busy, 0);
    tick = 0; cyc(); chk("pr still held", count, 6);
    start = 1; cyc(); start = 0;
    chk("pr resume busy", busy, 1); chk("pr resume count", count, 6);
    for (int k = 1; k <= 6; k++) begin
      tick = 1; cyc();
      chk("pr tick count", count, 6 - k);
      chk("pr tick tc", tc, k == 6);
      tick = 0; cyc();
      chk("pr gap count", count, 6 - k);
    end

    // priority collisions
    load_val = 6; load = 1; cyc(); load = 0;
    start = 1; cyc(); start = 0;
    tick = 1; cyc(); cyc(); tick = 0;
    chk("pri at 4", count, 4);
    load_val = 9; load = 1; start = 1; stop = 1; tick = 1; cyc(); idle_inputs();
    chk("pri count", count, 9); chk("pri busy", busy, 0);
    chk("pri done", done, 0); chk("pri tc", tc, 0);
    start = 1; cyc();
    chk("pri run", busy, 1);
    stop = 1; cyc(); idle_inputs();
    chk("pri stop+start hold", busy, 0); chk("pri hold count", count, 9);
    start = 1; cyc(); start = 0;
    chk("pri resume", busy, 1);

    // restart from DONE, then reset mid-count
    load_val = 5; load = 1; cyc(); load = 0;
    start = 1; cyc(); start = 0;
    tick = 1; repeat (5) cyc(); tick = 0;
    chk("rs done", done, 1);
    start = 1; cyc(); start = 0;
    chk("rs count", count, 5); chk("rs busy", busy, 1);
    tick = 1; repeat (3) cyc();
    chk("rs at 2", count, 2);
    rst = 1; cyc(); rst = 0; tick = 0;
    chk("mid rst count", count, 0); chk("mid rst busy", busy, 0);
    chk("mid rst tc", tc, 0);
    cyc(); chk("mid rst tc2", tc, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 29) == 0);
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      tick  = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 49) == 0) auto_reload = $urandom_range(0, 1);
      load_val = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
      cyc();
    end
    rst = 0; idle_inputs();
    load_val = 16'hFFFF; load = 1; cyc(); load = 0;
    chk("max load", count, 16'hFFFF);
    cmp_en = 1'b0;

    // 4-bit build, maximum period
    cyc(); rst4 = 0;
    lv4 = 4'hF; load4 = 1; cyc(); load4 = 0;
    start4 = 1; cyc(); start4 = 0;
    tick4 = 1; n = 0;
    while (n < 40) begin
      cyc(); n++;
      if (tc4 === 1'b1) break;
    end
    tick4 = 0;
    chk("w4 ticks to tc", n, 15);
    chk("w4 count", count4, 0); chk("w4 done", done4, 1); chk("w4 zero", zero4, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
